// File: rtl/fcs_mpc_pkg.sv
// Shared definitions for the FCS-MPC gate driver: leg states and default timing.
package fcs_mpc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DT_HI = 3'd1,
    ON_HI = 3'd2,
    DT_LO = 3'd3,
    ON_LO = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam int DEAD_CYC_DEFAULT   = 8;
  localparam int MIN_ON_CYC_DEFAULT = 40;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fcs_mpc_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, clears to 0 on reset.
module fcs_mpc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fcs_mpc_gate_driver.sv
// Complementary gate driver for the FCS-MPC switch decision: dead time, minimum
// on-time, fault lockout and a saturating count of committed transitions.
module fcs_mpc_gate_driver
  import fcs_mpc_pkg::*;
#(
  parameter int DEAD_CYC   = DEAD_CYC_DEFAULT,
  parameter int MIN_ON_CYC = MIN_ON_CYC_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic             sw_cmd,
  input  logic             cmd_valid,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             gate_hi,
  output logic             gate_lo,
  output logic             busy,
  output logic             fault_latch,
  output logic [CNT_W-1:0] sw_count
);

  localparam int DW = $clog2(max2(DEAD_CYC, MIN_ON_CYC) + 1);
  localparam logic [DW-1:0] DT_LAST = DW'(DEAD_CYC - 1);
  localparam logic [DW-1:0] ON_SAT  = DW'(MIN_ON_CYC);
  localparam logic [DW-1:0] ONE     = DW'(1);

  state_t        state, state_n;
  logic [DW-1:0] dwell, dwell_n;
  logic          pend_v, pend_cmd;
  logic          consume, clear_pend, count_inc;
  logic          fault_s;

  fcs_mpc_sync2 u_fault_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (fault_in),
    .q   (fault_s)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      dwell <= '0;
    end else begin
      state <= state_n;
      dwell <= dwell_n;
    end
  end

  // In IDLE the dwell counter marks one settle cycle with the request visible
  // before the dead time is armed, so a fresh start always lands at k+2+DEAD_CYC.
  always_comb begin
    state_n    = state;
    dwell_n    = dwell;
    consume    = 1'b0;
    clear_pend = 1'b0;
    count_inc  = 1'b0;
    if (fault_s) begin
      state_n    = FAULT;
      dwell_n    = '0;
      clear_pend = 1'b1;
    end else if (!enable && state != FAULT) begin
      state_n    = IDLE;
      dwell_n    = '0;
      clear_pend = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (pend_v) begin
            if (dwell == '0) begin
              dwell_n = ONE;
            end else begin
              consume = 1'b1;
              state_n = pend_cmd ? DT_HI : DT_LO;
              dwell_n = '0;
            end
          end
        end
        DT_HI, DT_LO: begin
          if (dwell == DT_LAST) begin
            state_n   = (state == DT_HI) ? ON_HI : ON_LO;
            dwell_n   = '0;
            count_inc = 1'b1;
          end else begin
            dwell_n = dwell + ONE;
          end
        end
        ON_HI, ON_LO: begin
          if (dwell != ON_SAT) begin
            dwell_n = dwell + ONE;
          end
          if (pend_v) begin
            if (pend_cmd == (state == ON_HI)) begin
              consume = 1'b1;
            end else if (dwell == ON_SAT) begin
              consume = 1'b1;
              state_n = (state == ON_HI) ? DT_LO : DT_HI;
              dwell_n = '0;
            end
          end
        end
        FAULT: begin
          clear_pend = 1'b1;
          if (fault_clr) begin
            state_n = IDLE;
            dwell_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
          dwell_n = '0;
        end
      endcase
    end
  end

  // A command arriving in the same cycle as a consumption overwrites the slot.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pend_v   <= 1'b0;
      pend_cmd <= 1'b0;
    end else if (clear_pend) begin
      pend_v <= 1'b0;
    end else if (cmd_valid) begin
      pend_v   <= 1'b1;
      pend_cmd <= sw_cmd;
    end else if (consume) begin
      pend_v <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      gate_hi     <= 1'b0;
      gate_lo     <= 1'b0;
      busy        <= 1'b0;
      fault_latch <= 1'b0;
      sw_count    <= '0;
    end else begin
      gate_hi     <= (state_n == ON_HI);
      gate_lo     <= (state_n == ON_LO);
      busy        <= (state_n == DT_HI) || (state_n == DT_LO);
      fault_latch <= (state_n == FAULT);
      if (count_inc && sw_count != {CNT_W{1'b1}}) begin
        sw_count <= sw_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fcs_mpc_gate_driver.sv
// Directed and randomized bench for fcs_mpc_gate_driver against an event-level leg model.
module tb_fcs_mpc_gate_driver;

  localparam int DEAD   = 8;
  localparam int MIN_ON = 40;
  localparam int CNT_W  = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable, sw_cmd, cmd_valid, fault_in, fault_clr;
  logic             gate_hi, gate_lo, busy, fault_latch;
  logic [CNT_W-1:0] sw_count;

  int tests = 0;
  int fails = 0;

  // Model state: active leg (0 none, 1 high, 2 low), remaining dead cycles,
  // time on the current leg, settle flag, fault lockout, pending slot, sync pipe.
  int m_leg = 0, m_target = 0, m_dead = 0, m_on = 0, m_count = 0;
  bit m_settle = 0, m_fault = 0, m_pv = 0, m_pc = 0, m_f1 = 0, m_f2 = 0;

  bit pulse_mon = 0;
  int hi_run = 0, lo_run = 0, off_run = 0;

  fcs_mpc_gate_driver #(
    .DEAD_CYC   (DEAD),
    .MIN_ON_CYC (MIN_ON),
    .CNT_W      (CNT_W)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .enable      (enable),
    .sw_cmd      (sw_cmd),
    .cmd_valid   (cmd_valid),
    .fault_in    (fault_in),
    .fault_clr   (fault_clr),
    .gate_hi     (gate_hi),
    .gate_lo     (gate_lo),
    .busy        (busy),
    .fault_latch (fault_latch),
    .sw_count    (sw_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit en, input bit cmd, input bit valid,
                                     input bit fin, input bit fclr);
    bit fs, wipe, used;
    int want;
    fs   = m_f2;
    wipe = 0;
    used = 0;
    if (fs) begin
      m_fault = 1; m_leg = 0; m_dead = 0; m_settle = 0; wipe = 1;
    end else if (!en && !m_fault) begin
      m_leg = 0; m_dead = 0; m_settle = 0; wipe = 1;
    end else if (m_fault) begin
      wipe = 1;
      if (fclr) begin
        m_fault = 0; m_settle = 0;
      end
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) begin
        m_leg = m_target;
        m_on  = 0;
        if (m_count < CMAX) m_count++;
      end
    end else if (m_leg == 0) begin
      if (m_pv) begin
        if (!m_settle) m_settle = 1;
        else begin
          used = 1; m_settle = 0; m_target = m_pc ? 1 : 2; m_dead = DEAD;
        end
      end
    end else begin
      want = m_pc ? 1 : 2;
      if (m_pv && want == m_leg) used = 1;
      else if (m_pv && m_on >= MIN_ON) begin
        used = 1; m_leg = 0; m_target = want; m_dead = DEAD;
      end
      if (m_leg != 0 && m_on < MIN_ON) m_on++;
    end
    if (wipe) m_pv = 0;
    else if (valid) begin
      m_pv = 1; m_pc = cmd;
    end else if (used) m_pv = 0;
    m_f2 = m_f1;
    m_f1 = fin;
  endfunction

  task automatic apply_stimulus(input bit en, input bit cmd, input bit valid,
                                input bit fin, input bit fclr);
    enable    = en;
    sw_cmd    = cmd;
    cmd_valid = valid;
    fault_in  = fin;
    fault_clr = fclr;
    model_step(en, cmd, valid, fin, fclr);
    @(posedge clk);
    #1;
    check_output("gate_hi", 32'(gate_hi), 32'(m_leg == 1));
    check_output("gate_lo", 32'(gate_lo), 32'(m_leg == 2));
    check_output("busy", 32'(busy), 32'(m_dead > 0));
    check_output("fault_latch", 32'(fault_latch), 32'(m_fault));
    check_output("sw_count", 32'(sw_count), 32'(m_count));
    check_output("no_overlap", 32'(gate_hi & gate_lo), 32'd0);
    if (pulse_mon) begin
      if (gate_hi) hi_run++;
      else begin
        if (hi_run > 0) check_output("hi_min_on", 32'(hi_run >= MIN_ON), 32'd1);
        hi_run = 0;
      end
      if (gate_lo) lo_run++;
      else begin
        if (lo_run > 0) check_output("lo_min_on", 32'(lo_run >= MIN_ON), 32'd1);
        lo_run = 0;
      end
      if (!gate_hi && !gate_lo) off_run++;
      else begin
        if (off_run > 0) check_output("off_gap", 32'(off_run >= DEAD), 32'd1);
        off_run = 0;
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    enable = 0; sw_cmd = 0; cmd_valid = 0; fault_in = 0; fault_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_gate_hi", 32'(gate_hi), 32'd0);
    check_output("rst_gate_lo", 32'(gate_lo), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_fault_latch", 32'(fault_latch), 32'd0);
    check_output("rst_sw_count", 32'(sw_count), 32'd0);
    #2 rst = 1'b0;

    // Startup latency: command at edge 10, high gate after edge 20.
    idle_steps(9);
    apply_stimulus(1, 1, 1, 0, 0);
    idle_steps(9);
    check_output("t1_hi_before", 32'(gate_hi), 32'd0);
    idle_steps(1);
    check_output("t1_hi_on", 32'(gate_hi), 32'd1);
    check_output("t1_lo_off", 32'(gate_lo), 32'd0);
    check_output("t1_count", 32'(sw_count), 32'd1);

    // Opposite command held until minimum on-time, then a full dead time.
    idle_steps(4);
    apply_stimulus(1, 0, 1, 0, 0);
    idle_steps(35);
    check_output("t2_hi_held", 32'(gate_hi), 32'd1);
    idle_steps(1);
    check_output("t2_hi_off", 32'(gate_hi), 32'd0);
    check_output("t2_busy", 32'(busy), 32'd1);
    idle_steps(7);
    check_output("t2_lo_wait", 32'(gate_lo), 32'd0);
    idle_steps(1);
    check_output("t2_lo_on", 32'(gate_lo), 32'd1);
    check_output("t2_count", 32'(sw_count), 32'd2);

    // Pending opposite command overwritten by a same-leg command.
    idle_steps(5);
    apply_stimulus(1, 1, 1, 0, 0);
    idle_steps(4);
    apply_stimulus(1, 0, 1, 0, 0);
    idle_steps(50);
    check_output("t3_lo_kept", 32'(gate_lo), 32'd1);
    check_output("t3_count", 32'(sw_count), 32'd2);

    // Fault during a dead time, clear refused while the fault is present.
    apply_stimulus(1, 1, 1, 0, 0);
    idle_steps(3);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 1, 0);
    check_output("t4_latched", 32'(fault_latch), 32'd1);
    check_output("t4_gates", 32'({gate_hi, gate_lo}), 32'd0);
    check_output("t4_count", 32'(sw_count), 32'd2);
    apply_stimulus(1, 0, 0, 1, 1);
    check_output("t4_clr_ignored", 32'(fault_latch), 32'd1);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 1, 0, 0);
    apply_stimulus(1, 0, 0, 0, 1);
    check_output("t4_cleared", 32'(fault_latch), 32'd0);

    // Enable drop in ON_LO clears the pending slot; restart needs a full dead time.
    apply_stimulus(1, 0, 1, 0, 0);
    idle_steps(10);
    check_output("t5_lo_on", 32'(gate_lo), 32'd1);
    idle_steps(12);
    apply_stimulus(1, 1, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t5_lo_dropped", 32'(gate_lo), 32'd0);
    idle_steps(5);
    check_output("t5_pend_cleared", 32'(gate_hi | busy), 32'd0);
    apply_stimulus(1, 0, 1, 0, 0);
    idle_steps(9);
    check_output("t5_lo_wait", 32'(gate_lo), 32'd0);
    idle_steps(1);
    check_output("t5_lo_back", 32'(gate_lo), 32'd1);
    check_output("t5_count", 32'(sw_count), 32'd4);

    // Random command stream with pulse-width and gap monitoring.
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0);
    hi_run = 0; lo_run = 0; off_run = 1000; pulse_mon = 1;
    for (int i = 0; i < 10000; i++) begin
      apply_stimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), 0, 0);
    end
    pulse_mon = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
